wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback stage that sits directly upstream of the register file and drives its single write port.
- Arbitrates result sources with valid/ready handshakes:
  - ALU/execute results
  - LSU load-return results
- Registers the winning result for one cycle, then presents it as reg_write/write_addr/write_data.
- Exports the same registered result as a bypass for decode.
- A starvation counter guarantees the ALU source forward progress under continuous LSU traffic.

Parameters:
- XLEN, `XLEN (32): data width.
- RFIDX_WIDTH, `RFIDX_WIDTH (5): register index width.
- STARVE_LIMIT, 4: consecutive lost ALU cycles before ALU is forced to win. Legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- alu_wb_valid  input  1  ALU result valid
- alu_wb_ready  output  1  ALU result accepted this cycle
- alu_wb_rd  input  RFIDX_WIDTH  ALU destination register
- alu_wb_data  input  XLEN  ALU result
- lsu_wb_valid  input  1  LSU result valid
- lsu_wb_ready  output  1  LSU result accepted this cycle
- lsu_wb_rd  input  RFIDX_WIDTH  LSU destination register
- lsu_wb_data  input  XLEN  LSU result
- flush  input  1  synchronous kill of grants and of the staged write
- reg_write  output  1  regfile write enable
- write_addr  output  RFIDX_WIDTH  regfile write index
- write_data  output  XLEN  regfile write data
- fwd_valid  output  1  bypass valid; equals reg_write
- fwd_rd  output  RFIDX_WIDTH  bypass index
- fwd_data  output  XLEN  bypass data

Behaviour:
- Reset (rst_n low, asynchronous): all outputs are 0, and the starvation counter is 0.
- Handshake:
  - A transfer occurs in a cycle where valid && ready.
  - The ready outputs are combinational from the valids, flush and the counter.
  - At most one ready is high per cycle.
  - The stage never back-pressures downstream; the regfile always accepts.
- Grant rules, evaluated each cycle:
  - flush = 1: no grant; both readies are 0.
  - Only one source valid: that source wins.
  - Both valid and starve_cnt < STARVE_LIMIT: LSU wins.
  - Both valid and starve_cnt == STARVE_LIMIT: ALU wins.
- Starvation counter:
  - Width 4 bits.
  - Increments when alu_wb_valid && !alu_wb_ready && !flush.
  - Saturates at STARVE_LIMIT.
  - Clears to 0 on any ALU grant.
  - Holds when alu_wb_valid = 0.
  - Holds on flush.
- Latency: a grant in cycle N produces its output on the rising edge ending cycle N, so it is visible during cycle N+1:
  - reg_write = 1 and write_addr = rd, unless rd == 0 (see below).
  - write_data = data.
- No-grant cycles: reg_write = 0 the next cycle. write_addr and write_data hold their last values.
- rd == 0:
  - The handshake still completes (the source is drained).
  - reg_write stays 0 in cycle N+1 (x0 is never written).
  - fwd_valid stays 0.
  - write_addr and write_data still update.
- flush:
  - flush in cycle N forces reg_write = 0 in cycle N+1, including a result that would have been staged this cycle.
  - It does not cancel an already-visible write in cycle N; that write commits at the regfile on the cycle-N edge.
- Reset asserted mid-operation: the staged write is discarded immediately (reg_write drops asynchronously) and the counter clears. Sources must re-present their data after reset.
- fwd_* outputs mirror reg_write/write_addr/write_data exactly. They cover the cycle in which the regfile has not yet committed the write.

Optional Feature:
- Macro: WB_ARBITER_PERF_EN.
- When defined, adds these outputs:
  - perf_alu_cnt (32): ALU grants
  - perf_lsu_cnt (32): LSU grants
  - perf_conflict_cnt (32): cycles with both valid and no flush
  - perf_x0_cnt (32): grants with rd == 0
- Counter behaviour: reset to 0 asynchronously, increment once per qualifying cycle, wrap at 2^32.
- When not defined: these ports and registers do not exist, and all other behaviour is identical.

Test Plan:
- Reset: assert rst_n = 0 while both valids are high → all outputs 0, no readies after release until the next evaluation; release → first grant in the first post-reset cycle.
- Single ALU transfer: alu valid, rd = 7, data = 0xDEADBEEF, cycle 0 → alu_wb_ready = 1 in cycle 0; in cycle 1 reg_write = 1, write_addr = 7, write_data = 0xDEADBEEF, fwd_valid = 1.
- Conflict and starvation (STARVE_LIMIT = 4): both valid continuously →
  - lsu_wb_ready high in cycles 0–3
  - alu_wb_ready high in cycle 4, counter back to 0
  - LSU wins cycles 5–8, ALU wins cycle 9
- x0 write: lsu rd = 0, data = 0x55 → lsu_wb_ready = 1; next cycle reg_write = 0, fwd_valid = 0; with WB_ARBITER_PERF_EN, perf_x0_cnt = 1.
- Flush: grant ALU rd = 3 in cycle 0 → reg_write high in cycle 1. Assert flush in cycle 1 with lsu valid → lsu_wb_ready = 0 in cycle 1, reg_write = 0 in cycle 2, starvation counter unchanged.
- Async reset mid-write: pulse rst_n low mid-cycle while reg_write = 1 → reg_write drops to 0 without a clock edge; counters read 0.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks an ALU or LSU result, stages it for one cycle and drives the regfile
// write port plus the decode bypass. Optional perf counters are enabled by WB_ARBITER_PERF_EN.
module wb_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned RFIDX_WIDTH  = 5,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_wb_valid,
  output logic                   alu_wb_ready,
  input  logic [RFIDX_WIDTH-1:0] alu_wb_rd,
  input  logic [XLEN-1:0]        alu_wb_data,
  input  logic                   lsu_wb_valid,
  output logic                   lsu_wb_ready,
  input  logic [RFIDX_WIDTH-1:0] lsu_wb_rd,
  input  logic [XLEN-1:0]        lsu_wb_data,
  input  logic                   flush,
`ifdef WB_ARBITER_PERF_EN
  output logic [31:0]            perf_alu_cnt,
  output logic [31:0]            perf_lsu_cnt,
  output logic [31:0]            perf_conflict_cnt,
  output logic [31:0]            perf_x0_cnt,
`endif
  output logic                   reg_write,
  output logic [RFIDX_WIDTH-1:0] write_addr,
  output logic [XLEN-1:0]        write_data,
  output logic                   fwd_valid,
  output logic [RFIDX_WIDTH-1:0] fwd_rd,
  output logic [XLEN-1:0]        fwd_data
);

  localparam logic [3:0] StarveLim = 4'(STARVE_LIMIT);

  logic [3:0]             starve_q, starve_d;
  logic                   grant;
  logic [RFIDX_WIDTH-1:0] sel_rd;
  logic [XLEN-1:0]        sel_data;
  logic                   reg_write_q, reg_write_d;
  logic [RFIDX_WIDTH-1:0] write_addr_q;
  logic [XLEN-1:0]        write_data_q;

  // Readies are held low while reset is asserted so every output reads 0 during reset.
  always_comb begin
    alu_wb_ready = 1'b0;
    lsu_wb_ready = 1'b0;
    if (rst_n && !flush) begin
      if (alu_wb_valid && (!lsu_wb_valid || (starve_q == StarveLim))) begin
        alu_wb_ready = 1'b1;
      end else if (lsu_wb_valid) begin
        lsu_wb_ready = 1'b1;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (alu_wb_ready) begin
      starve_d = 4'd0;
    end else if (alu_wb_valid && !flush && (starve_q < StarveLim)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    grant       = alu_wb_ready | lsu_wb_ready;
    sel_rd      = alu_wb_ready ? alu_wb_rd : lsu_wb_rd;
    sel_data    = alu_wb_ready ? alu_wb_data : lsu_wb_data;
    reg_write_d = grant && (sel_rd != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q     <= 4'd0;
      reg_write_q  <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      starve_q    <= starve_d;
      reg_write_q <= reg_write_d;
      // Address and data track every grant, x0 included; only the enable is suppressed.
      if (grant) begin
        write_addr_q <= sel_rd;
        write_data_q <= sel_data;
      end
    end
  end

  assign reg_write  = reg_write_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign fwd_valid  = reg_write_q;
  assign fwd_rd     = write_addr_q;
  assign fwd_data   = write_data_q;

`ifdef WB_ARBITER_PERF_EN
  logic [31:0] perf_alu_q, perf_lsu_q, perf_conflict_q, perf_x0_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_alu_q      <= '0;
      perf_lsu_q      <= '0;
      perf_conflict_q <= '0;
      perf_x0_q       <= '0;
    end else begin
      if (alu_wb_ready) perf_alu_q <= perf_alu_q + 32'd1;
      if (lsu_wb_ready) perf_lsu_q <= perf_lsu_q + 32'd1;
      if (alu_wb_valid && lsu_wb_valid && !flush) perf_conflict_q <= perf_conflict_q + 32'd1;
      if (grant && (sel_rd == '0)) perf_x0_q <= perf_x0_q + 32'd1;
    end
  end

  assign perf_alu_cnt      = perf_alu_q;
  assign perf_lsu_cnt      = perf_lsu_q;
  assign perf_conflict_cnt = perf_conflict_q;
  assign perf_x0_cnt       = perf_x0_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed, table-driven bench for wb_arbiter (default STARVE_LIMIT = 4).
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_wb_valid, alu_wb_ready;
  logic [4:0]  alu_wb_rd;
  logic [31:0] alu_wb_data;
  logic        lsu_wb_valid, lsu_wb_ready;
  logic [4:0]  lsu_wb_rd;
  logic [31:0] lsu_wb_data;
  logic        flush;
  logic        reg_write, fwd_valid;
  logic [4:0]  write_addr, fwd_rd;
  logic [31:0] write_data, fwd_data;
`ifdef WB_ARBITER_PERF_EN
  logic [31:0] perf_alu_cnt, perf_lsu_cnt, perf_conflict_cnt, perf_x0_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_ready (alu_wb_ready),
    .alu_wb_rd    (alu_wb_rd),
    .alu_wb_data  (alu_wb_data),
    .lsu_wb_valid (lsu_wb_valid),
    .lsu_wb_ready (lsu_wb_ready),
    .lsu_wb_rd    (lsu_wb_rd),
    .lsu_wb_data  (lsu_wb_data),
    .flush        (flush),
`ifdef WB_ARBITER_PERF_EN
    .perf_alu_cnt      (perf_alu_cnt),
    .perf_lsu_cnt      (perf_lsu_cnt),
    .perf_conflict_cnt (perf_conflict_cnt),
    .perf_x0_cnt       (perf_x0_cnt),
`endif
    .reg_write    (reg_write),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .fwd_valid    (fwd_valid),
    .fwd_rd       (fwd_rd),
    .fwd_data     (fwd_data)
  );

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        fl;
    logic        ear;
    logic        elr;
    logic        erw;
    logic [4:0]  ea;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic fl);
    alu_wb_valid = av;
    alu_wb_rd    = ard;
    alu_wb_data  = ad;
    lsu_wb_valid = lv;
    lsu_wb_rd    = lrd;
    lsu_wb_data  = ld;
    flush        = fl;
  endtask

  task automatic check_outputs(input string tag, input logic erw, input logic [4:0] ea,
                               input logic [31:0] ed);
    check({tag, " reg_write"}, 32'(reg_write), 32'(erw));
    check({tag, " write_addr"}, 32'(write_addr), 32'(ea));
    check({tag, " write_data"}, write_data, ed);
    check({tag, " fwd_valid"}, 32'(fwd_valid), 32'(erw));
    check({tag, " fwd_rd"}, 32'(fwd_rd), 32'(ea));
    check({tag, " fwd_data"}, fwd_data, ed);
  endtask

  // Called just after a rising edge; checks readies mid-cycle and staged outputs after the edge.
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    drive(v.av, v.ard, v.ad, v.lv, v.lrd, v.ld, v.fl);
    @(negedge clk);
    check({tag, " alu_ready"}, 32'(alu_wb_ready), 32'(v.ear));
    check({tag, " lsu_ready"}, 32'(lsu_wb_ready), 32'(v.elr));
    @(posedge clk);
    #1;
    check_outputs(tag, v.erw, v.ea, v.ed);
  endtask

  initial begin
    // Single ALU transfer
    vecs.push_back('{1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'hDEADBEEF});
    // Conflict: LSU wins four times, then ALU, then again
    vecs.push_back('{1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 32'h22});
    vecs.push_back('{1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h23, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 32'h23});
    vecs.push_back('{1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h24, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 32'h24});
    vecs.push_back('{1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h25, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 32'h25});
    vecs.push_back('{1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h26, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 32'h11});
    vecs.push_back('{1'b1, 5'd1, 32'h12, 1'b1, 5'd2, 32'h27, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 32'h27});
    vecs.push_back('{1'b1, 5'd1, 32'h12, 1'b1, 5'd2, 32'h28, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 32'h28});
    vecs.push_back('{1'b1, 5'd1, 32'h12, 1'b1, 5'd2, 32'h29, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 32'h29});
    vecs.push_back('{1'b1, 5'd1, 32'h12, 1'b1, 5'd2, 32'h2A, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 32'h2A});
    vecs.push_back('{1'b1, 5'd1, 32'h12, 1'b1, 5'd2, 32'h2B, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 32'h12});
    // Idle: enable drops, address/data hold
    vecs.push_back('{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 32'h12});
    // LSU to x0: drained, never written
    vecs.push_back('{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h55});
    // ALU rd=3, then flush with LSU valid while that write is visible
    vecs.push_back('{1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h33});
    vecs.push_back('{1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h44, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'h33});
    // Flush mid-conflict must not advance the starvation count
    vecs.push_back('{1'b1, 5'd5, 32'h50, 1'b1, 5'd6, 32'h61, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6, 32'h61});
    vecs.push_back('{1'b1, 5'd5, 32'h50, 1'b1, 5'd6, 32'h62, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6, 32'h62});
    vecs.push_back('{1'b1, 5'd5, 32'h50, 1'b1, 5'd6, 32'h63, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6, 32'h63});
    vecs.push_back('{1'b1, 5'd5, 32'h50, 1'b1, 5'd6, 32'h64, 1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 32'h63});
    vecs.push_back('{1'b1, 5'd5, 32'h50, 1'b1, 5'd6, 32'h65, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6, 32'h65});
    vecs.push_back('{1'b1, 5'd5, 32'h50, 1'b1, 5'd6, 32'h66, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h50});
    // ALU to x0, then LSU alone
    vecs.push_back('{1'b1, 5'd0, 32'h77, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h77});
    vecs.push_back('{1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h88, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 32'h88});

    // Reset with both sources valid: everything reads 0
    rst_n = 1'b0;
    drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst alu_ready", 32'(alu_wb_ready), 32'd0);
    check("rst lsu_ready", 32'(lsu_wb_ready), 32'd0);
    check_outputs("rst", 1'b0, 5'd0, 32'd0);
    // Release mid-cycle: the first post-reset cycle grants LSU
    #2 rst_n = 1'b1;
    #1;
    check("post_rst alu_ready", 32'(alu_wb_ready), 32'd0);
    check("post_rst lsu_ready", 32'(lsu_wb_ready), 32'd1);
    @(posedge clk);
    #1;
    check_outputs("post_rst", 1'b1, 5'd10, 32'hAA);

    // Clean reset so the table starts from a zero starvation count
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Build the starvation count to 2, then reset asynchronously while a write is visible
    drive(1'b1, 5'd11, 32'hB1, 1'b1, 5'd12, 32'hC1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("pre_async reg_write", 32'(reg_write), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async alu_ready", 32'(alu_wb_ready), 32'd0);
    check("async lsu_ready", 32'(lsu_wb_ready), 32'd0);
    check_outputs("async", 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // A cleared count lets LSU win four more times before ALU is forced through
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("async_seq%0d alu_ready", k), 32'(alu_wb_ready), (k == 4) ? 32'd1 : 32'd0);
      check($sformatf("async_seq%0d lsu_ready", k), 32'(lsu_wb_ready), (k == 4) ? 32'd0 : 32'd1);
      @(negedge clk);
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
